// File: rtl/ap_ctrl_perf_monitor.sv
// ap_ctrl_perf_monitor: per-channel ap_ctrl_chain handshake statistics
// (counts, latency min/max/last/sum, stalls) with a registered readout port.
`default_nettype none

module ap_ctrl_perf_monitor #(
    parameter  int N_CH      = 4,
    parameter  int CNT_W     = 32,
    parameter  int TS_W      = 16,
    parameter  int OUT_DEPTH = 4,
    localparam int RCW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic [N_CH-1:0]  mon_ap_start,
    input  logic [N_CH-1:0]  mon_ap_ready,
    input  logic [N_CH-1:0]  mon_ap_done,
    input  logic [N_CH-1:0]  mon_ap_continue,
    input  logic             clear,
    input  logic             freeze,
    input  logic [RCW-1:0]   rd_ch,
    input  logic [2:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             any_err
);

    localparam int PW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int OCW = $clog2(OUT_DEPTH + 1);
    localparam int SW  = ((CNT_W > TS_W) ? CNT_W : TS_W) + 1;
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == C_CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [TS_W-1:0]  r_ts;
    logic [CNT_W-1:0] w_start_cnt [N_CH];
    logic [CNT_W-1:0] w_done_cnt  [N_CH];
    logic [CNT_W-1:0] w_stall_cnt [N_CH];
    logic [CNT_W-1:0] w_lat_sum   [N_CH];
    logic [TS_W-1:0]  w_lat_last  [N_CH];
    logic [TS_W-1:0]  w_lat_min   [N_CH];
    logic [TS_W-1:0]  w_lat_max   [N_CH];
    logic [OCW-1:0]   w_outst     [N_CH];
    logic [N_CH-1:0]  w_ovf;
    logic [N_CH-1:0]  w_unf;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) r_ts <= '0;
        else           r_ts <= r_ts + TS_W'(1);
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic            w_start_acc, w_done_acc, w_stall;
        logic            w_empty, w_full, w_pop, w_push, w_zero_lat;
        logic            w_lat_upd, w_ovf_evt, w_unf_evt;
        logic [TS_W-1:0] w_lat;
        logic [SW-1:0]   w_sum_wide;
        logic [TS_W-1:0] r_fifo [OUT_DEPTH];
        logic [PW-1:0]   r_wp, r_rp;
        logic [OCW-1:0]  r_cnt;
        logic [CNT_W-1:0] r_start_cnt, r_done_cnt, r_stall_cnt, r_lat_sum;
        logic [TS_W-1:0] r_lat_last, r_lat_min, r_lat_max;
        logic            r_ovf, r_unf;

        assign w_start_acc = mon_ap_start[g] & mon_ap_ready[g];
        assign w_done_acc  = mon_ap_done[g] & mon_ap_continue[g];
        assign w_stall     = mon_ap_done[g] & ~mon_ap_continue[g];
        assign w_empty     = (r_cnt == '0);
        assign w_full      = (r_cnt == OCW'(OUT_DEPTH));
        assign w_pop       = w_done_acc & ~w_empty;
        // Start and done together on an empty FIFO is a zero-latency pass-through.
        assign w_zero_lat  = w_done_acc & w_start_acc & w_empty;
        assign w_push      = w_start_acc & ~w_zero_lat & (~w_full | w_pop);
        assign w_ovf_evt   = w_start_acc & w_full & ~w_pop;
        assign w_unf_evt   = w_done_acc & w_empty & ~w_start_acc;
        assign w_lat_upd   = w_pop | w_zero_lat;
        assign w_lat       = w_pop ? (r_ts - r_fifo[r_rp]) : '0;
        assign w_sum_wide  = SW'(r_lat_sum) + SW'(w_lat);

        always_ff @(posedge ap_clk) begin
            if (ap_rst_n && !clear && !freeze && w_push) r_fifo[r_wp] <= r_ts;
        end

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                r_wp <= '0; r_rp <= '0; r_cnt <= '0;
                r_start_cnt <= '0; r_done_cnt <= '0; r_stall_cnt <= '0; r_lat_sum <= '0;
                r_lat_last <= '0; r_lat_min <= '1; r_lat_max <= '0;
                r_ovf <= 1'b0; r_unf <= 1'b0;
            end else if (clear) begin
                r_wp <= '0; r_rp <= '0; r_cnt <= '0;
                r_start_cnt <= '0; r_done_cnt <= '0; r_stall_cnt <= '0; r_lat_sum <= '0;
                r_lat_last <= '0; r_lat_min <= '1; r_lat_max <= '0;
                r_ovf <= 1'b0; r_unf <= 1'b0;
            end else if (!freeze) begin
                if (w_start_acc) r_start_cnt <= sat_inc(r_start_cnt);
                if (w_done_acc)  r_done_cnt  <= sat_inc(r_done_cnt);
                if (w_stall)     r_stall_cnt <= sat_inc(r_stall_cnt);
                if (w_lat_upd) begin
                    r_lat_last <= w_lat;
                    if (w_lat < r_lat_min) r_lat_min <= w_lat;
                    if (w_lat > r_lat_max) r_lat_max <= w_lat;
                    r_lat_sum <= (w_sum_wide > SW'(C_CNT_MAX)) ? C_CNT_MAX
                                                               : w_sum_wide[CNT_W-1:0];
                end
                if (w_push) r_wp <= ptr_nxt(r_wp);
                if (w_pop)  r_rp <= ptr_nxt(r_rp);
                r_cnt <= r_cnt + OCW'(w_push) - OCW'(w_pop);
                if (w_ovf_evt) r_ovf <= 1'b1;
                if (w_unf_evt) r_unf <= 1'b1;
            end
        end

        assign w_start_cnt[g] = r_start_cnt;
        assign w_done_cnt[g]  = r_done_cnt;
        assign w_stall_cnt[g] = r_stall_cnt;
        assign w_lat_sum[g]   = r_lat_sum;
        assign w_lat_last[g]  = r_lat_last;
        assign w_lat_min[g]   = r_lat_min;
        assign w_lat_max[g]   = r_lat_max;
        assign w_outst[g]     = r_cnt;
        assign w_ovf[g]       = r_ovf;
        assign w_unf[g]       = r_unf;
    end

    logic [CNT_W-1:0] w_rd_mux;
    logic [7:0]       w_outst8;
    logic [3:0]       w_outst4;

    always_comb begin
        w_rd_mux = '0;
        w_outst8 = '0;
        w_outst4 = '0;
        if (32'(rd_ch) < N_CH) begin
            w_outst8 = 8'(w_outst[rd_ch]);
            w_outst4 = (w_outst8 > 8'd15) ? 4'hF : w_outst8[3:0];
            case (rd_sel)
                3'd0: w_rd_mux = w_start_cnt[rd_ch];
                3'd1: w_rd_mux = w_done_cnt[rd_ch];
                3'd2: w_rd_mux = CNT_W'(w_lat_last[rd_ch]);
                3'd3: w_rd_mux = CNT_W'(w_lat_min[rd_ch]);
                3'd4: w_rd_mux = CNT_W'(w_lat_max[rd_ch]);
                3'd5: w_rd_mux = w_lat_sum[rd_ch];
                3'd6: w_rd_mux = w_stall_cnt[rd_ch];
                default: w_rd_mux = CNT_W'({w_outst4, 2'b00, w_unf[rd_ch], w_ovf[rd_ch]});
            endcase
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rd_data <= '0;
            any_err <= 1'b0;
        end else begin
            rd_data <= w_rd_mux;
            any_err <= (|w_ovf) | (|w_unf);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Scoreboard bench for ap_ctrl_perf_monitor: a default instance and a small
// (TS_W=8, CNT_W=4) instance for timestamp wrap and counter saturation.
`default_nettype none

module tb_ap_ctrl_perf_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b0;

    logic [3:0]  s0 = '0, r0 = '0, d0 = '0, c0 = '0;
    logic        clr0 = 1'b0, frz0 = 1'b0;
    logic [1:0]  ch0 = '0;
    logic [2:0]  sel0 = '0;
    logic [31:0] q0;
    logic        e0;

    logic [2:0]  s1 = '0, r1 = '0, d1 = '0, c1 = '0;
    logic        clr1 = 1'b0, frz1 = 1'b0;
    logic [1:0]  ch1 = '0;
    logic [2:0]  sel1 = '0;
    logic [3:0]  q1;
    logic        e1;

    ap_ctrl_perf_monitor #(.N_CH(4), .CNT_W(32), .TS_W(16), .OUT_DEPTH(4)) dut0 (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .mon_ap_start(s0), .mon_ap_ready(r0), .mon_ap_done(d0), .mon_ap_continue(c0),
        .clear(clr0), .freeze(frz0), .rd_ch(ch0), .rd_sel(sel0),
        .rd_data(q0), .any_err(e0));

    ap_ctrl_perf_monitor #(.N_CH(3), .CNT_W(4), .TS_W(8), .OUT_DEPTH(2)) dut1 (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .mon_ap_start(s1), .mon_ap_ready(r1), .mon_ap_done(d1), .mon_ap_continue(c1),
        .clear(clr1), .freeze(frz1), .rd_ch(ch1), .rd_sel(sel1),
        .rd_data(q1), .any_err(e1));

    typedef struct {
        int          dut;
        int          kind;   // 0: rd_data, 1: any_err
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        m_e;
    logic [31:0] m_act;
    int          n_vec = 0;
    int          n_bad = 0;
    logic        rd_req = 1'b0;
    logic        rd_vld = 1'b0;
    int          edge_no = 0;

    // Timestamp the next sampling edge will see.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_no <= 0;
        else        edge_no <= edge_no + 1;
    end

    always @(posedge clk) rd_vld <= rd_req;

    always @(negedge clk) begin
        if (rd_vld) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_underrun: output presented with no expectation queued");
            end else begin
                m_e = sb.pop_front();
                if (m_e.dut == 0) m_act = (m_e.kind == 1) ? {31'b0, e0} : q0;
                else              m_act = (m_e.kind == 1) ? {31'b0, e1} : {28'b0, q1};
                if (m_act !== m_e.exp) begin
                    n_bad++;
                    $display("FAIL %s: got 0x%0h, expected 0x%0h", m_e.name, m_act, m_e.exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int dut, input int kind, input int ch, input int sel,
                       input logic [31:0] exp, input string nm);
        exp_t t;
        if (dut == 0) begin ch0 = 2'(ch); sel0 = 3'(sel); end
        else          begin ch1 = 2'(ch); sel1 = 3'(sel); end
        t.dut = dut; t.kind = kind; t.exp = exp; t.name = nm;
        sb.push_back(t);
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
    endtask

    task automatic hs(input int dut, input int ch, input bit st, input bit dn);
        if (dut == 0) begin s0[ch] = st; r0[ch] = st; d0[ch] = dn; c0[ch] = dn; end
        else          begin s1[ch] = st; r1[ch] = st; d1[ch] = dn; c1[ch] = dn; end
        step();
        s0 = '0; r0 = '0; d0 = '0; c0 = '0;
        s1 = '0; r1 = '0; d1 = '0; c1 = '0;
    endtask

    task automatic wait_ts(input int t, input int m);
        int guard = 0;
        while ((edge_no % m) != t && guard < 70000) begin
            step();
            guard++;
        end
    endtask

    initial begin
        int s_edge;
        int guard;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk(0, 0, 0, 0, 32'h0,        "rst_start_cnt");
        chk(0, 0, 0, 3, 32'hFFFF,     "rst_lat_min");
        chk(0, 1, 0, 0, 32'h0,        "rst_any_err");
        chk(1, 0, 0, 3, 32'hF,        "rst_lat_min_small");

        // ch0: start at ts 10, done at ts 25
        wait_ts(10, 65536);
        hs(0, 0, 1, 0);
        wait_ts(25, 65536);
        hs(0, 0, 0, 1);
        chk(0, 0, 0, 0, 32'd1,  "ch0_start_cnt");
        chk(0, 0, 0, 1, 32'd1,  "ch0_done_cnt");
        chk(0, 0, 0, 2, 32'd15, "ch0_lat_last");
        chk(0, 0, 0, 3, 32'd15, "ch0_lat_min");
        chk(0, 0, 0, 4, 32'd15, "ch0_lat_max");
        chk(0, 0, 0, 5, 32'd15, "ch0_lat_sum");
        chk(0, 0, 0, 7, 32'h0,  "ch0_status");

        // ch1: four pipelined transactions, latency 20 each
        s_edge = edge_no;
        repeat (4) hs(0, 1, 1, 0);
        chk(0, 0, 1, 7, 32'h40, "ch1_status_full");
        while (edge_no < s_edge + 20) step();
        repeat (4) hs(0, 1, 0, 1);
        chk(0, 0, 1, 0, 32'd4,  "ch1_start_cnt");
        chk(0, 0, 1, 1, 32'd4,  "ch1_done_cnt");
        chk(0, 0, 1, 3, 32'd20, "ch1_lat_min");
        chk(0, 0, 1, 4, 32'd20, "ch1_lat_max");
        chk(0, 0, 1, 5, 32'd80, "ch1_lat_sum");
        chk(0, 0, 1, 7, 32'h0,  "ch1_status_drained");
        chk(0, 1, 0, 0, 32'h0,  "any_err_before_ovf");
        repeat (5) hs(0, 1, 1, 0);
        chk(0, 0, 1, 7, 32'h41, "ch1_status_ovf");
        chk(0, 0, 1, 0, 32'd9,  "ch1_start_cnt_ovf");
        chk(0, 1, 0, 0, 32'h1,  "any_err_ovf");

        // ch2: start, then done held 7 cycles without continue
        hs(0, 2, 1, 0);
        d0[2] = 1'b1; c0[2] = 1'b0;
        repeat (7) step();
        c0[2] = 1'b1;
        step();
        d0[2] = 1'b0; c0[2] = 1'b0;
        chk(0, 0, 2, 6, 32'd7, "ch2_stall_cnt");
        chk(0, 0, 2, 1, 32'd1, "ch2_done_cnt");
        chk(0, 0, 2, 2, 32'd8, "ch2_lat_last");
        chk(0, 0, 2, 7, 32'h0, "ch2_status");

        // ch3: zero-latency pass-through, then lone done
        hs(0, 3, 1, 1);
        chk(0, 0, 3, 2, 32'd0, "ch3_lat_last_zero");
        chk(0, 0, 3, 3, 32'd0, "ch3_lat_min_zero");
        chk(0, 0, 3, 0, 32'd1, "ch3_start_cnt");
        chk(0, 0, 3, 1, 32'd1, "ch3_done_cnt");
        chk(0, 0, 3, 7, 32'h0, "ch3_status_clean");
        hs(0, 3, 0, 1);
        chk(0, 0, 3, 7, 32'h2, "ch3_status_unf");
        chk(0, 0, 3, 1, 32'd2, "ch3_done_cnt_unf");

        // small instance: timestamp wrap 250 -> 4
        wait_ts(250, 256);
        hs(1, 0, 1, 0);
        wait_ts(4, 256);
        hs(1, 0, 0, 1);
        chk(1, 0, 0, 2, 32'd10, "wrap_lat_last");
        chk(1, 0, 0, 3, 32'd10, "wrap_lat_min");
        chk(1, 0, 0, 5, 32'd10, "wrap_lat_sum");

        // saturation and overflow on a 2-deep FIFO
        repeat (20) hs(1, 1, 1, 0);
        chk(1, 0, 1, 0, 32'hF, "sat_start_cnt");
        chk(1, 0, 1, 7, 32'h1, "sat_status_ovf");
        chk(1, 1, 0, 0, 32'h1, "small_any_err");

        // clear in the middle of a start burst
        s1[1] = 1'b1; r1[1] = 1'b1;
        step(); step();
        clr1 = 1'b1;
        step();
        clr1 = 1'b0; s1 = '0; r1 = '0;
        chk(1, 0, 1, 0, 32'h0, "clr_start_cnt");
        chk(1, 0, 1, 7, 32'h0, "clr_status");
        chk(1, 0, 0, 3, 32'hF, "clr_lat_min");
        chk(1, 0, 0, 2, 32'h0, "clr_lat_last");
        chk(1, 1, 0, 0, 32'h0, "clr_any_err");

        // freeze
        frz1 = 1'b1;
        repeat (3) hs(1, 2, 1, 0);
        frz1 = 1'b0;
        chk(1, 0, 2, 0, 32'h0, "frz_start_cnt");
        hs(1, 2, 1, 0);
        chk(1, 0, 2, 0, 32'h1, "post_frz_start_cnt");
        chk(1, 0, 3, 0, 32'h0, "rd_ch_out_of_range");

        // reset mid-transaction drops the timestamp; the later done underflows
        hs(0, 0, 1, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        hs(0, 0, 0, 1);
        chk(0, 0, 0, 7, 32'h2, "rst_mid_status_unf");
        chk(0, 0, 0, 0, 32'h0, "rst_mid_start_cnt");
        chk(0, 1, 0, 0, 32'h1, "rst_mid_any_err");

        guard = 0;
        step(); step();
        while (sb.size() != 0 && guard < 100) begin
            step();
            guard++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
